input_event_capture: RTL and testbench
======================================

Name: input_event_capture

Overview:
- Memory-mapped peripheral on the 68000 bus that timestamps input transitions for latency measurement.
- Monitors the gamepad word and the 7 user-port lines.
- Each cycle in which any enabled line changes pushes one entry into a FIFO: 32-bit timestamp, changed-mask, new line levels.
- CPU drains the FIFO through the register window; a level IRQ feeds the interrupt flagging logic.

Parameters:
- DEPTH_LOG2, 4: FIFO holds 2^DEPTH_LOG2 entries.
- LOCKOUT_CYCLES, 16'd48000: per-line re-trigger lockout length. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  block selected by bus decode
- wr  in  2  byte write strobes; [0]=low byte, [1]=high byte; 00 means no write
- address  in  4  word register index (cpu_addr[4:1])
- din  in  16  write data
- dout  out  16  read data, combinational from address and state
- gamepad  in  16  pad buttons, synchronous to clk
- user_in  in  7  user port lines, asynchronous
- irq  out  1  level interrupt request

Behaviour:
- Register map (word index):
  - 0 STATUS (RO): [DEPTH_LOG2:0]=count, [8]=empty, [9]=full, [10]=overflow (sticky). Writing with bit 10 set clears overflow.
  - 1 CTRL (RW): [0]=capture enable, [1]=irq enable, [2]=flush (write-1, self-clearing, reads 0).
  - 2 MASK_PAD (RW, 16 bits). 3 MASK_USER (RW, bits [6:0]). A set bit enables capture on that line.
  - 4 TS_HI, 5 TS_LO: head entry timestamp.
  - 6 CHG_PAD, 7 CHG_USER: head changed-mask.
  - 8 LVL_PAD, 9 LVL_USER: head levels.
  - 10 POP (WO): any nonzero wr discards the head entry.
  - 11 NOW_HI, 12 NOW_LO: live timestamp counter. Writing NOW_LO latches NOW_HI for a coherent read pair; NOW_HI reads the latched value.
  - Unmapped indices read 0.
- Head registers read 0 while empty.
- Byte strobes apply independently to RW registers.
- Writes act only when cs=1 and wr≠00.
- Input path:
  - All 23 lines pass through 2 flops (cs-independent). Pad index 0-15, user index 16-22.
  - change = sync ^ prev; prev <= sync every cycle, regardless of enable.
  - eff = change & mask.
  - Line edge at clock T (first sampled) yields an entry whose timestamp = counter value at T+2. Entry is visible in head/STATUS from T+3.
- Timestamp counter: 32-bit, +1 every clk, wraps 0xFFFFFFFF->0. No saturation.
- Push occurs when enable=1 and eff≠0. One entry per cycle; simultaneous edges on several lines share one entry.
- FIFO boundary rules:
  - Full and no pop that cycle: entry dropped, overflow<=1.
  - Pop and push in the same cycle while full: both accepted, no overflow.
  - Pop while empty: ignored.
  - Flush: count<=0, pointers<=0. A push in the same cycle is discarded and does not set overflow.
- irq = irq_en & ~empty. It deasserts the cycle after the pop that empties the FIFO.
- Reset (async, any time): counter 0, FIFO empty, overflow 0, CTRL 0, masks 0, sync/prev flops 0, dout reflects reset state, irq 0.
- Enable 1->0 mid-stream keeps queued entries readable.
- Enabling while a line is held generates no entry, because prev tracks continuously.

Optional Feature:
- Macro: INPUT_EVENT_CAPTURE_LOCKOUT_EN.
- Defined:
  - Each line has a lockout counter. After a line contributes to a pushed entry, further changes on that line are excluded from eff for LOCKOUT_CYCLES clocks; prev still tracks.
  - The counter reloads only on contribution.
  - Flush and reset clear all counters.
  - A line change that is excluded while the FIFO is full still starts lockout.
- Undefined: no counters; every enabled change is captured.

Test Plan:
- Reset, CTRL=1, MASK_PAD=0x0001; raise gamepad[0] at counter=100 -> one entry: TS=102, CHG_PAD=0x0001, LVL_PAD=0x0001, count=1.
- Raise user_in[3] and gamepad[15] on the same clock with both masks 0xFFFF -> single entry: CHG_PAD=0x8000, CHG_USER=0x0008.
- DEPTH_LOG2=4; generate 17 edges without popping -> count=16, full=1, overflow=1. Pop once, then one edge -> count=16, overflow still 1 until STATUS written with 0x0400.
- CTRL=3, one edge -> irq=1; POP -> irq=0 next cycle. A further POP leaves count=0.
- Preload counter near wrap via long run; edge at 0xFFFFFFFE -> TS_HI=0x0000, TS_LO=0x0000 (wrapped).
- Assert reset mid-stream with count=5 -> count 0, irq 0, all registers 0 immediately. With lockout enabled, edges 10 clocks apart on one line yield one entry.

Source files
------------

// File: rtl/input_event_capture.sv
// Input event timestamper: syncs 23 input lines and queues one {timestamp, changed-mask, levels}
// entry per cycle with an enabled change. Optional per-line lockout: INPUT_EVENT_CAPTURE_LOCKOUT_EN.
module input_event_capture #(
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter logic [15:0] LOCKOUT_CYCLES = 16'd48000,
    parameter logic [31:0] TS_RESET       = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  wr,
    input  logic [3:0]  address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic [15:0] gamepad,
    input  logic [6:0]  user_in,
    output logic        irq
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned NL    = 23;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef struct packed {
        logic [31:0]   ts;
        logic [NL-1:0] chg;
        logic [NL-1:0] lvl;
    } entry_t;

    logic [NL-1:0]         r_sync1, r_sync2, r_prev;
    logic [31:0]           r_now;
    logic [15:0]           r_now_hi;
    logic                  r_cap_en, r_irq_en, r_overflow;
    logic [15:0]           r_mask_pad;
    logic [6:0]            r_mask_user;
    entry_t                r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic                  w_we, w_we_lo, w_we_hi;
    logic                  w_flush, w_pop_req, w_pop, w_push_req, w_push, w_drop;
    logic                  w_empty, w_full;
    logic [NL-1:0]         w_change, w_eff;
    logic [15:0]           w_status;
    entry_t                w_head;

    // Bus writes: a write takes effect on the clock edge where cs=1 and wr!=00; no wait states.
    assign w_we    = cs && (wr != 2'b00);
    assign w_we_lo = cs && wr[0];
    assign w_we_hi = cs && wr[1];

    assign w_flush   = w_we_lo && (address == 4'd1) && din[2];
    assign w_pop_req = w_we && (address == 4'd10);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_change  = r_sync2 ^ r_prev;

`ifdef INPUT_EVENT_CAPTURE_LOCKOUT_EN
    logic [15:0]   r_lock [NL];
    logic [NL-1:0] w_locked;

    always_comb begin
        for (int i = 0; i < NL; i++) w_locked[i] = (r_lock[i] != 16'd0);
    end

    assign w_eff = w_change & {r_mask_user, r_mask_pad} & ~w_locked;

    // Lockout starts on any contribution, even one dropped because the FIFO was full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) r_lock[i] <= 16'd0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (w_flush)                   r_lock[i] <= 16'd0;
                else if (r_cap_en && w_eff[i]) r_lock[i] <= LOCKOUT_CYCLES;
                else if (w_locked[i])          r_lock[i] <= r_lock[i] - 16'd1;
            end
        end
    end
`else
    assign w_eff = w_change & {r_mask_user, r_mask_pad};
`endif

    assign w_push_req = r_cap_en && (w_eff != '0) && !w_flush;
    assign w_pop      = w_pop_req && !w_empty && !w_flush;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{ts: r_now, chg: w_eff, lvl: r_sync2};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev      <= '0;
            r_now       <= TS_RESET;
            r_now_hi    <= 16'd0;
            r_cap_en    <= 1'b0;
            r_irq_en    <= 1'b0;
            r_overflow  <= 1'b0;
            r_mask_pad  <= 16'd0;
            r_mask_user <= 7'd0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else begin
            r_sync1 <= {user_in, gamepad};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_now   <= r_now + 32'd1;

            if (w_we_lo && address == 4'd1) begin
                r_cap_en <= din[0];
                r_irq_en <= din[1];
            end
            if (w_we_lo && address == 4'd2) r_mask_pad[7:0]  <= din[7:0];
            if (w_we_hi && address == 4'd2) r_mask_pad[15:8] <= din[15:8];
            if (w_we_lo && address == 4'd3) r_mask_user      <= din[6:0];
            if (w_we && address == 4'd12)   r_now_hi         <= r_now[31:16];

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_we_hi && address == 4'd0 && din[10]) r_overflow <= 1'b0;
            if (w_drop)                                r_overflow <= 1'b1;

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_ONE;
                if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
                if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
                else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
            end
        end
    end

    assign irq = r_irq_en && !w_empty;

    always_comb begin
        w_status               = 16'd0;
        w_status[DEPTH_LOG2:0] = r_count;
        w_status[8]            = w_empty;
        w_status[9]            = w_full;
        w_status[10]           = r_overflow;
    end

    always_comb begin
        w_head = w_empty ? '0 : r_mem[r_rptr];
        dout   = 16'd0;
        case (address)
            4'd0:    dout = w_status;
            4'd1:    dout = {14'd0, r_irq_en, r_cap_en};
            4'd2:    dout = r_mask_pad;
            4'd3:    dout = {9'd0, r_mask_user};
            4'd4:    dout = w_head.ts[31:16];
            4'd5:    dout = w_head.ts[15:0];
            4'd6:    dout = w_head.chg[15:0];
            4'd7:    dout = {9'd0, w_head.chg[22:16]};
            4'd8:    dout = w_head.lvl[15:0];
            4'd9:    dout = {9'd0, w_head.lvl[22:16]};
            4'd11:   dout = r_now_hi;
            4'd12:   dout = r_now[15:0];
            default: dout = 16'd0;
        endcase
    end
endmodule

// File: tb/tb_input_event_capture.sv
// Directed bench for input_event_capture; a second instance starts its timestamp near wrap.
module tb_input_event_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [1:0]  wr;
    logic [3:0]  address;
    logic [15:0] din;
    logic [15:0] gamepad;
    logic [6:0]  user_in;
    logic [15:0] dout, dout_w;
    logic        irq, irq_w;

    int unsigned exp_now;
    int          checks = 0;
    int          errors = 0;

    input_event_capture dut (
        .clk(clk), .reset(reset), .cs(cs), .wr(wr), .address(address), .din(din),
        .dout(dout), .gamepad(gamepad), .user_in(user_in), .irq(irq)
    );

    input_event_capture #(.TS_RESET(32'hFFFF_FFF0)) dut_w (
        .clk(clk), .reset(reset), .cs(cs), .wr(wr), .address(address), .din(din),
        .dout(dout_w), .gamepad(gamepad), .user_in(user_in), .irq(irq_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        exp_now = exp_now + 1;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
        cs = 1'b1; wr = s; address = a; din = d;
        tick();
        cs = 1'b0; wr = 2'b00; din = 16'd0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a);
        address = a;
        #1;
    endtask

    task automatic wait_now(input int unsigned target);
        int guard = 0;
        while (exp_now != target && guard < 100000) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; wr = 2'b00; address = 4'd0; din = 16'd0;
        gamepad = 16'd0; user_in = 7'd0; exp_now = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_now = 0;

        rd(4'd0);  check("reset_status", dout, 16'h0100);
        check("reset_irq", {15'd0, irq}, 16'd0);
        rd(4'd1);  check("reset_ctrl", dout, 16'h0000);
        rd(4'd12); check("reset_now_lo", dout, 16'h0000);
        rd(4'd5);  check("reset_head_ts", dout, 16'h0000);

        // Single edge on pad[0] while the counter reads 100.
        bus_write(4'd1, 16'h0001, 2'b11);
        bus_write(4'd2, 16'h0001, 2'b11);
        wait_now(100);
        gamepad = 16'h0001;
        ticks(2);
        rd(4'd0);  check("latency_not_yet", dout, 16'h0100);
        tick();
        rd(4'd0);  check("one_entry_status", dout, 16'h0001);
        rd(4'd4);  check("one_ts_hi", dout, 16'h0000);
        rd(4'd5);  check("one_ts_lo", dout, 16'd102);
        rd(4'd6);  check("one_chg_pad", dout, 16'h0001);
        rd(4'd8);  check("one_lvl_pad", dout, 16'h0001);
        rd(4'd7);  check("one_chg_user", dout, 16'h0000);
        rd(4'd12); check("now_lo_live", dout, 16'(exp_now));
        bus_write(4'd10, 16'h0000, 2'b11);
        rd(4'd0);  check("pop_to_empty", dout, 16'h0100);
        rd(4'd5);  check("empty_head_zero", dout, 16'h0000);

        // Simultaneous edges on user[3] and pad[15] share one entry.
        bus_write(4'd2, 16'hFFFF, 2'b11);
        bus_write(4'd3, 16'hFFFF, 2'b11);
        rd(4'd3);  check("mask_user_rd", dout, 16'h007F);
        gamepad = 16'h8001; user_in = 7'h08;
        ticks(3);
        rd(4'd0);  check("multi_status", dout, 16'h0001);
        rd(4'd6);  check("multi_chg_pad", dout, 16'h8000);
        rd(4'd7);  check("multi_chg_user", dout, 16'h0008);
        rd(4'd8);  check("multi_lvl_pad", dout, 16'h8001);
        rd(4'd9);  check("multi_lvl_user", dout, 16'h0008);
        bus_write(4'd10, 16'h0000, 2'b01);

        bus_write(4'd2, 16'h1234, 2'b01);
        rd(4'd2);  check("byte_strobe_lo", dout, 16'hFF34);
        bus_write(4'd2, 16'hFFFF, 2'b11);

        // Fill past capacity.
        for (int i = 0; i < 17; i++) begin
            gamepad[1] = ~gamepad[1];
            tick();
        end
        ticks(3);
        rd(4'd0);  check("full_overflow", dout, 16'h0610);
        check("irq_disabled", {15'd0, irq}, 16'd0);
        bus_write(4'd10, 16'h0000, 2'b11);
        rd(4'd0);  check("pop_from_full", dout, 16'h040F);
        gamepad[1] = ~gamepad[1];
        ticks(3);
        rd(4'd0);  check("refill_sticky", dout, 16'h0610);
        bus_write(4'd0, 16'h0400, 2'b01);
        rd(4'd0);  check("ovf_clear_lo_only", dout, 16'h0610);
        bus_write(4'd0, 16'h0400, 2'b11);
        rd(4'd0);  check("ovf_clear", dout, 16'h0210);
        gamepad[1] = ~gamepad[1];
        ticks(2);
        bus_write(4'd10, 16'h0000, 2'b11);
        rd(4'd0);  check("pop_push_full", dout, 16'h0210);
        gamepad[1] = ~gamepad[1];
        ticks(3);
        rd(4'd0);  check("drop_sets_ovf", dout, 16'h0610);
        bus_write(4'd0, 16'h0400, 2'b10);
        gamepad[1] = ~gamepad[1];
        ticks(2);
        bus_write(4'd1, 16'h0005, 2'b11);
        rd(4'd0);  check("flush_discards_push", dout, 16'h0100);
        rd(4'd1);  check("flush_self_clear", dout, 16'h0001);

        // Interrupt follows non-empty when enabled.
        bus_write(4'd1, 16'h0003, 2'b11);
        gamepad[1] = ~gamepad[1];
        ticks(3);
        check("irq_set", {15'd0, irq}, 16'd1);
        bus_write(4'd10, 16'h0000, 2'b11);
        check("irq_clear", {15'd0, irq}, 16'd0);
        bus_write(4'd10, 16'h0000, 2'b11);
        rd(4'd0);  check("pop_empty_ignored", dout, 16'h0100);

        // Enabling while a line is held produces nothing.
        bus_write(4'd1, 16'h0000, 2'b11);
        gamepad[2] = 1'b1;
        ticks(3);
        bus_write(4'd1, 16'h0001, 2'b11);
        ticks(3);
        rd(4'd0);  check("enable_while_held", dout, 16'h0100);

        // Queue five, disable, then reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            gamepad[1] = ~gamepad[1];
            tick();
        end
        ticks(3);
        bus_write(4'd1, 16'h0002, 2'b11);
        rd(4'd0);  check("disable_keeps", dout, 16'h0005);
        check("irq_five", {15'd0, irq}, 16'd1);
        reset = 1'b1;
        #1;
        rd(4'd0);  check("rst_status", dout, 16'h0100);
        check("rst_irq", {15'd0, irq}, 16'd0);
        rd(4'd1);  check("rst_ctrl", dout, 16'h0000);
        rd(4'd2);  check("rst_mask", dout, 16'h0000);
        rd(4'd12); check("rst_now", dout, 16'h0000);
        gamepad = 16'd0; user_in = 7'd0;
        tick();
        reset = 1'b0;
        exp_now = 0;

        // Wrap: second instance counter = 0xFFFFFFF0 + exp_now.
        bus_write(4'd1, 16'h0001, 2'b11);
        bus_write(4'd2, 16'h0001, 2'b11);
        bus_write(4'd12, 16'h0000, 2'b11);
        wait_now(14);
        gamepad = 16'h0001;
        ticks(3);
        rd(4'd4);  check("wrap_ts_hi", dout_w, 16'h0000);
        rd(4'd5);  check("wrap_ts_lo", dout_w, 16'h0000);
        check("plain_ts_lo", dout, 16'd16);
        rd(4'd11); check("wrap_now_hi_latched", dout_w, 16'hFFFF);
        check("plain_now_hi_latched", dout, 16'h0000);
        rd(4'd12); check("wrap_now_lo", dout_w, 16'(32'hFFFF_FFF0 + exp_now));
        bus_write(4'd10, 16'h0000, 2'b11);

        // Two edges ten clocks apart on one line.
        gamepad = 16'h0000;
        ticks(10);
        gamepad = 16'h0001;
        ticks(3);
        rd(4'd0);
`ifdef INPUT_EVENT_CAPTURE_LOCKOUT_EN
        check("lockout_one_entry", dout, 16'h0001);
`else
        check("no_lockout_two_entries", dout, 16'h0002);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
